uart_cmd_ctrl: RTL

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_cmd_ctrl.sv
// UART command decoder: turns 0x57 (write) / 0x52 (read) byte packets into register bus accesses.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned ADDR_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_req,
  output logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_error,
  output logic              bus_req,
  input  logic              bus_ready,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  output logic              resp_req,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              cmd_error
);

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

  state_t     state, state_nxt;
  logic [1:0] byte_cnt;
  logic       rx_fire;
  logic       valid_op;
  logic       timeout;
  logic       discard;

  assign rx_fire  = rx_req && rx_ready;
  assign valid_op = (rx_data == OP_WR) || (rx_data == OP_RD);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             receiving;

  assign receiving = (state == ADDR) || (state == DATA);
  // Fires on the cycle the idle gap would reach TIMEOUT_CYCLES, so IDLE starts exactly then.
  assign timeout   = receiving && !rx_fire && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              to_cnt <= '0;
    else if (rx_fire || !receiving || timeout) to_cnt <= '0;
    else                                    to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_fire && !rx_error && valid_op) state_nxt = ADDR;
      ADDR: begin
        if (rx_fire)      state_nxt = rx_error ? IDLE : (bus_wr ? DATA : BUS);
        else if (timeout) state_nxt = IDLE;
      end
      DATA: begin
        if (rx_fire)      state_nxt = rx_error ? IDLE : ((byte_cnt == 2'd3) ? BUS : DATA);
        else if (timeout) state_nxt = IDLE;
      end
      BUS:  if (bus_ready)  state_nxt = bus_wr ? IDLE : RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_ready = (state == IDLE) || (state == ADDR) || (state == DATA);
    bus_req  = (state == BUS);
    resp_req = (state == RESP);
    discard  = timeout || (rx_fire && (rx_error || ((state == IDLE) && !valid_op)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_wr    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      resp_data <= '0;
      byte_cnt  <= '0;
      cmd_error <= 1'b0;
    end else begin
      cmd_error <= discard;
      case (state)
        IDLE: if (rx_fire && !rx_error && valid_op) bus_wr <= (rx_data == OP_WR);
        ADDR: if (rx_fire && !rx_error) begin
          bus_addr <= ADDR_W'(rx_data);
          byte_cnt <= '0;
        end
        DATA: if (rx_fire && !rx_error) begin
          bus_wdata[8*byte_cnt +: 8] <= rx_data;
          byte_cnt                   <= byte_cnt + 1'b1;
        end
        BUS:  if (bus_ready && !bus_wr) resp_data <= bus_rdata;
        default: ;
      endcase
    end
  end

endmodule
